// File: rtl/sr_cmd_sequencer_pkg.sv
// sr_pkg: shared types and sizing for the srff bank write sequencer.
//   state_e    : sequencer FSM states
//   cnt_width(): pulse/settle timer width, sized to hold max(PULSE_W, SETTLE_CYC)
package sr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SET    = 2'd1,
        RST    = 2'd2,
        SETTLE = 2'd3
    } state_e;

    localparam int PULSE_W_DEF    = 1;
    localparam int SETTLE_CYC_DEF = 2;

    function automatic int cnt_width(input int pw, input int sc);
        int m;
        m = (pw > sc) ? pw : sc;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

    localparam int CNT_W_DEF = cnt_width(PULSE_W_DEF, SETTLE_CYC_DEF);

endpackage

// File: rtl/sr_cmd_sequencer_if.sv
// Request/response bundle of the srff bank write sequencer.
//   tgt   : requested bank value        (master -> slave)
//   valid : request valid               (master -> slave)
//   ready : sequencer idle, can accept  (slave -> master)
//   done  : one-cycle completion strobe (slave -> master)
//   err   : any read-back mismatch, valid with done
//   mism  : per-bit read-back mismatch, holds until the next done
interface sr_cmd_sequencer_if #(
    parameter int N = 8
);
    logic [N-1:0] tgt;
    logic         valid;
    logic         ready;
    logic         done;
    logic         err;
    logic [N-1:0] mism;

    modport master (output tgt, output valid, input ready, input done, input err, input mism);
    modport slave  (input tgt, input valid, output ready, output done, output err, output mism);
endinterface

// File: rtl/sr_cmd_sequencer_pulse_timer.sv
// sr_pulse_timer: loadable down-counter shared by the SET, RST and SETTLE phases.
//   clk, rst_n  : clock, async active-low reset
//   load_i      : load load_val_i this cycle (asserted on every phase entry)
//   load_val_i  : phase length minus one
//   tc_o        : terminal count, high in the last cycle of the phase
module sr_pulse_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturates at zero; every phase entry reloads, so it never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/sr_cmd_sequencer.sv
// sr_cmd_sequencer: write-side driver for a bank of N srff cells.
// Accepts a target vector, pulses s_o on the bits that must rise, then r_o on
// the bits that must fall, waits a settle window and reports the read-back.
//   clk, rst_n : clock, async active-low reset
//   req        : request/response bundle (slave side)
//   q_i        : live q outputs of the srff bank
//   s_o, r_o   : registered set / reset pulses to the bank (never both active)
module sr_cmd_sequencer
    import sr_pkg::*;
#(
    parameter int N          = 8,
    parameter int PULSE_W    = PULSE_W_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    sr_cmd_sequencer_if.slave   req,
    input  logic [N-1:0]        q_i,
    output logic [N-1:0]        s_o,
    output logic [N-1:0]        r_o
);

    localparam int CNT_W = cnt_width(PULSE_W, SETTLE_CYC);
    localparam logic [CNT_W-1:0] PW_LD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] SC_LD = CNT_W'(SETTLE_CYC - 1);

    state_e         state_q, state_d;
    logic [N-1:0]   tgt_q, tgt_d;
    logic [N-1:0]   setm_q, setm_d;
    logic [N-1:0]   rstm_q, rstm_d;
    logic [N-1:0]   s_q, s_d;
    logic [N-1:0]   r_q, r_d;
    logic [N-1:0]   mism_q, mism_d;
    logic           err_q, err_d;
    logic           done_q, done_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_tc;

    logic [N-1:0]   acc_setm, acc_rstm;

    assign acc_setm = req.tgt & ~q_i;
    assign acc_rstm = ~req.tgt & q_i;

    sr_pulse_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tc_o       (tmr_tc)
    );

    // Pulse outputs are loaded on the same edge as the state, so s_o/r_o are
    // glitch-free and the SET->RST hand-over drops s and raises r together.
    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        setm_d   = setm_q;
        rstm_d   = rstm_q;
        s_d      = '0;
        r_d      = '0;
        mism_d   = mism_q;
        err_d    = err_q;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;

        unique case (state_q)
            IDLE: begin
                if (req.valid) begin
                    tgt_d    = req.tgt;
                    setm_d   = acc_setm;
                    rstm_d   = acc_rstm;
                    tmr_load = 1'b1;
                    if (acc_setm != '0) begin
                        state_d = SET;
                        s_d     = acc_setm;
                        tmr_val = PW_LD;
                    end else if (acc_rstm != '0) begin
                        state_d = RST;
                        r_d     = acc_rstm;
                        tmr_val = PW_LD;
                    end else begin
                        state_d = SETTLE;
                        tmr_val = SC_LD;
                    end
                end
            end
            SET: begin
                tmr_load = tmr_tc;
                if (!tmr_tc) begin
                    s_d = setm_q;
                end else if (rstm_q != '0) begin
                    state_d = RST;
                    r_d     = rstm_q;
                    tmr_val = PW_LD;
                end else begin
                    state_d = SETTLE;
                    tmr_val = SC_LD;
                end
            end
            RST: begin
                tmr_load = tmr_tc;
                if (!tmr_tc) begin
                    r_d = rstm_q;
                end else begin
                    state_d = SETTLE;
                    tmr_val = SC_LD;
                end
            end
            SETTLE: begin
                if (tmr_tc) begin
                    state_d = IDLE;
                    mism_d  = q_i ^ tgt_q;
                    err_d   = |(q_i ^ tgt_q);
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            setm_q  <= '0;
            rstm_q  <= '0;
            s_q     <= '0;
            r_q     <= '0;
            mism_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            setm_q  <= setm_d;
            rstm_q  <= rstm_d;
            s_q     <= s_d;
            r_q     <= r_d;
            mism_q  <= mism_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign s_o       = s_q;
    assign r_o       = r_q;
    assign req.ready = (state_q == IDLE);
    assign req.done  = done_q;
    assign req.err   = err_q;
    assign req.mism  = mism_q;

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Testbench for sr_cmd_sequencer: models an 8-cell srff bank driven by s_o/r_o,
// issues directed and random requests, and checks pulses, handshake, latency
// and read-back against a timeline model through a scoreboard queue.
module tb_sr_cmd_sequencer;

    localparam int N  = 8;
    localparam int PW = 2;
    localparam int SC = 2;

    typedef struct {
        logic [N-1:0] tgt;
        logic [N-1:0] sm;
        logic [N-1:0] rm;
        logic [N-1:0] mism;
        logic         err;
        int           lat;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] bank = '0;
    logic [N-1:0] stuck = '0;
    logic         pre_en = 1'b0;
    logic [N-1:0] pre_val = '0;
    logic [N-1:0] q_eff;
    logic [N-1:0] s_o, r_o;
    int           cyc = 0;
    int           n_chk = 0;
    int           n_fail = 0;
    exp_t         sbq[$];
    logic [N-1:0] hold_mism = '0;

    sr_cmd_sequencer_if #(.N(N)) req ();

    sr_cmd_sequencer #(.N(N), .PULSE_W(PW), .SETTLE_CYC(SC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .q_i   (q_eff),
        .s_o   (s_o),
        .r_o   (r_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // srff bank model: set wins over hold, reset clears; stuck bits read as 0.
    always @(posedge clk) begin
        if (pre_en) bank <= pre_val;
        else        bank <= (bank & ~r_o) | s_o;
    end
    assign q_eff = bank & ~stuck;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Issue side: every handshake pushes the expected outcome of that request.
    always @(negedge clk) begin
        if (rst_n && req.valid && req.ready) begin
            exp_t e;
            int   lat;
            e.tgt  = req.tgt;
            e.sm   = req.tgt & ~q_eff;
            e.rm   = ~req.tgt & q_eff;
            lat    = 1 + SC;
            if (e.sm != 0) lat += PW;
            if (e.rm != 0) lat += PW;
            e.lat  = lat;
            e.mism = (((q_eff & ~e.rm) | e.sm) & ~stuck) ^ req.tgt;
            e.err  = (e.mism != 0);
            e.acc  = cyc + 1;
            sbq.push_back(e);
        end
    end

    // Monitor: derives the expected pulse timeline of the oldest request from
    // its age in cycles, and pops it when the completion is due.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_mism <= '0;
        end else begin
            logic [N-1:0] es, er;
            logic         ed, erdy;
            int           k, pws;
            exp_t         e;
            es = '0; er = '0; ed = 1'b0; erdy = 1'b1; k = 0;
            if (sbq.size() > 0) begin
                e = sbq[0];
                k = cyc - e.acc + 1;
                if (k >= 1) begin
                    pws = (e.sm != 0) ? PW : 0;
                    if (e.sm != 0 && k <= PW) es = e.sm;
                    if (e.rm != 0 && k > pws && k <= pws + PW) er = e.rm;
                    erdy = (k >= e.lat);
                    ed   = (k == e.lat);
                end
            end
            chk("s_o", 32'(s_o), 32'(es));
            chk("r_o", 32'(r_o), 32'(er));
            chk("no_overlap", 32'((|(s_o & r_o)) || (|s_o && |r_o)), 32'(0));
            chk("ready_o", 32'(req.ready), 32'(erdy));
            chk("done_o", 32'(req.done), 32'(ed));
            if (ed) begin
                chk("err_o", 32'(req.err), 32'(e.err));
                chk("mism_o", 32'(req.mism), 32'(e.mism));
                hold_mism <= e.mism;
                void'(sbq.pop_front());
            end else begin
                chk("mism_hold", 32'(req.mism), 32'(hold_mism));
            end
        end
    end

    task automatic preload(input logic [N-1:0] v);
        @(posedge clk); #1;
        pre_en = 1'b1; pre_val = v;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    // Raise valid with t until accepted, then keep valid up for 'extra' more
    // cycles presenting hold_t (accepted again only if the DUT frees up).
    task automatic send(input logic [N-1:0] t, input logic [N-1:0] hold_t, input int extra);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        req.valid = 1'b1; req.tgt = t;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req.ready) begin ok = 1'b1; break; end
        end
        chk("accept_timeout", 32'(ok), 32'(1));
        @(posedge clk); #1;
        for (int i = 0; i < extra; i++) begin
            req.tgt = hold_t;
            @(posedge clk); #1;
        end
        req.valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (sbq.size() == 0) begin ok = 1'b1; break; end
        end
        chk("idle_timeout", 32'(ok), 32'(1));
    endtask

    initial begin
        req.valid = 1'b0;
        req.tgt   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_o", 32'(s_o), 32'(0));
        chk("rst_r_o", 32'(r_o), 32'(0));
        chk("rst_done", 32'(req.done), 32'(0));
        chk("rst_err", 32'(req.err), 32'(0));
        chk("rst_mism", 32'(req.mism), 32'(0));
        chk("rst_ready", 32'(req.ready), 32'(1));
        rst_n = 1'b1;

        // set-only, set+reset, no-change, stuck bit
        preload(8'h00); send(8'hA5, 8'h00, 0); wait_idle();
        chk("bank_after_A5", 32'(q_eff), 32'(8'hA5));
        send(8'h5A, 8'h00, 0); wait_idle();
        chk("bank_after_5A", 32'(q_eff), 32'(8'h5A));
        preload(8'h3C); send(8'h3C, 8'h00, 0); wait_idle();
        preload(8'h00);
        @(posedge clk); #1 stuck = 8'h01;
        send(8'h01, 8'h00, 0); wait_idle();
        @(posedge clk); #1 stuck = 8'h00;

        // valid held through busy cycles, re-accepted in the done cycle
        preload(8'h00);
        send(8'h0F, 8'hFF, 12); wait_idle();
        chk("bank_after_hold", 32'(q_eff), 32'(8'hFF));

        // reset during SET aborts: pulses drop at once, no completion
        preload(8'h00);
        @(posedge clk); #1;
        req.valid = 1'b1; req.tgt = 8'hF0;
        @(negedge clk);
        @(posedge clk); #1;
        req.valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_s_o", 32'(s_o), 32'(0));
        chk("abort_r_o", 32'(r_o), 32'(0));
        chk("abort_ready", 32'(req.ready), 32'(1));
        chk("abort_done", 32'(req.done), 32'(0));
        sbq.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // random traffic
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) preload(N'($urandom));
            if ($urandom_range(0, 5) == 0) begin
                @(posedge clk); #1 stuck = N'(1) << $urandom_range(0, N - 1);
            end
            send(N'($urandom), N'($urandom), $urandom_range(0, 7));
            wait_idle();
            @(posedge clk); #1 stuck = '0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
